// File: rtl/count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_ctrl
// Purpose  : Start/pause/resume sequencer for the 4-digit counter datapath.
//            Turns debounced button levels and the divider tick into
//            registered enable/clear/direction strobes for the counter,
//            with terminal-count detection and hold-to-clear while running.
// Revision : 1.0  initial release
// ============================================================================
module count_ctrl #(
    parameter int MAX_COUNT  = 9999,
    parameter int CW         = 14,
    parameter int HOLD_TICKS = 3,
    parameter int WRAP       = 1
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active low
    input  logic          start_in,
    input  logic          clear_in,
    input  logic          dir_in,
    input  logic          tick,
    input  logic [CW-1:0] count,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic          cnt_up,
    output logic          run,
    output logic          done,
    output logic [1:0]    state
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_RUN   = 2'b01;
    localparam logic [1:0] c_PAUSE = 2'b10;
    localparam logic [1:0] c_DONE  = 2'b11;

    // Hold counter only ever holds 0 .. HOLD_TICKS-1; it is cleared on completion.
    localparam int            c_HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0]   c_MAX       = CW'(MAX_COUNT);

    logic [1:0]      r_state;
    logic            r_start_q;
    logic            r_clear_q;
    logic            r_dir_q;
    logic [c_HW-1:0] r_hold;
    logic            r_cnt_en;
    logic            r_cnt_clr;
    logic            r_cnt_up;

    logic            w_start_edge;
    logic            w_clear_edge;
    logic            w_dir_edge;
    logic            w_terminal;
    logic            w_hold_done;
    logic [1:0]      w_state_nxt;
    logic            w_en_nxt;
    logic            w_clr_nxt;
    logic            w_up_nxt;
    logic [c_HW-1:0] w_hold_nxt;

    assign w_start_edge = start_in & ~r_start_q;
    assign w_clear_edge = clear_in & ~r_clear_q;
    assign w_dir_edge   = dir_in   & ~r_dir_q;

    // Terminal depends on the direction the counter is currently moving.
    assign w_terminal  = r_cnt_up ? (count == c_MAX) : (count == '0);

    // The tick that completes the hold is consumed by the clear, not by counting.
    assign w_hold_done = (r_state == c_RUN) & clear_in & tick & (r_hold == c_HOLD_LAST);

    // Next-state and next-strobe decode; clear action beats start edge beats tick.
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_clr_nxt   = 1'b0;
        w_up_nxt    = r_cnt_up;
        w_hold_nxt  = '0;

        if ((r_state == c_RUN) && clear_in && !w_hold_done) begin
            w_hold_nxt = tick ? (r_hold + c_HW'(1)) : r_hold;
        end

        case (r_state)
            c_IDLE: begin
                if (w_clear_edge) begin
                    w_clr_nxt = 1'b1;
                end else if (w_start_edge) begin
                    w_state_nxt = c_RUN;
                end
                if (w_dir_edge) begin
                    w_up_nxt = ~r_cnt_up;
                end
            end
            c_RUN: begin
                if (w_hold_done) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (w_start_edge) begin
                    w_state_nxt = c_PAUSE;
                end else if (tick) begin
                    if (w_terminal && (WRAP == 0)) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_en_nxt = 1'b1;
                    end
                end
            end
            c_PAUSE: begin
                if (w_clear_edge) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (w_start_edge) begin
                    w_state_nxt = c_RUN;
                end
                if (w_dir_edge) begin
                    w_up_nxt = ~r_cnt_up;
                end
            end
            c_DONE: begin
                // Both clear and start leave DONE the same way: clear and go idle.
                if (w_clear_edge || w_start_edge) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // State, edge history, hold counter and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_start_q <= 1'b0;
            r_clear_q <= 1'b0;
            r_dir_q   <= 1'b0;
            r_hold    <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_cnt_up  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start_in;
            r_clear_q <= clear_in;
            r_dir_q   <= dir_in;
            r_hold    <= w_hold_nxt;
            r_cnt_en  <= w_en_nxt;
            r_cnt_clr <= w_clr_nxt;
            r_cnt_up  <= w_up_nxt;
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_clr = r_cnt_clr;
    assign cnt_up  = r_cnt_up;
    assign state   = r_state;
    assign run     = (r_state == c_RUN);
    assign done    = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_ctrl
// Purpose  : Self-checking bench for count_ctrl. Two instances (WRAP=1 and
//            WRAP=0) share all stimulus; an event-level reference model
//            predicts every output on every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_count_ctrl;

    localparam int CW    = 14;
    localparam int MAXC  = 9999;
    localparam int HT    = 3;
    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int DONE  = 3;

    // Where a start edge takes each mode (DONE also emits a clear).
    localparam int START_TO[4] = '{RUN, PAUSE, RUN, IDLE};

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       up;
        logic [3:0] hold;
    } mstate_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          dir_in = 1'b0;
    logic          tick = 1'b0;
    logic [CW-1:0] count = 14'd5;

    logic       en_w, clr_w, up_w, run_w, done_w;
    logic [1:0] st_w;
    logic       en_s, clr_s, up_s, run_s, done_s;
    logic [1:0] st_s;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt_w = 0;
    int clr_cnt_w = 0;

    always #5 clk = ~clk;

    count_ctrl #(.MAX_COUNT(MAXC), .CW(CW), .HOLD_TICKS(HT), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .start_in(start_in), .clear_in(clear_in), .dir_in(dir_in),
        .tick(tick), .count(count), .cnt_en(en_w), .cnt_clr(clr_w), .cnt_up(up_w),
        .run(run_w), .done(done_w), .state(st_w)
    );

    count_ctrl #(.MAX_COUNT(MAXC), .CW(CW), .HOLD_TICKS(HT), .WRAP(0)) u_stop (
        .clk(clk), .rst(rst), .start_in(start_in), .clear_in(clear_in), .dir_in(dir_in),
        .tick(tick), .count(count), .cnt_en(en_s), .cnt_clr(clr_s), .cnt_up(up_s),
        .run(run_s), .done(done_s), .state(st_s)
    );

    // ---------------- reference model ----------------
    mstate_t m_w, m_s, n_w, n_s;
    logic    m_sp, m_cp, m_dp;
    logic    se, ce, de;

    assign se = start_in & ~m_sp;
    assign ce = clear_in & ~m_cp;
    assign de = dir_in & ~m_dp;

    function automatic mstate_t step(input mstate_t c, input bit wrap, input logic s_e,
                                     input logic c_e, input logic d_e, input logic tk,
                                     input logic clr_lvl, input logic [CW-1:0] cnt);
        mstate_t n;
        int      s0;
        bit      term;
        bit      full;
        bit      clear_act;
        s0    = int'(c.st);
        n     = c;
        n.en  = 1'b0;
        n.clr = 1'b0;
        term  = c.up ? (int'(cnt) == MAXC) : (int'(cnt) == 0);
        full  = (s0 == RUN) && clr_lvl && tk && (int'(c.hold) + 1 == HT);
        clear_act = (s0 == RUN) ? full : c_e;
        if (clear_act) begin
            n.clr = 1'b1;
            n.st  = 2'(IDLE);
        end else if (s_e) begin
            n.st  = 2'(START_TO[s0]);
            n.clr = (s0 == DONE);
        end else if (tk && s0 == RUN) begin
            if (term && !wrap) n.st = 2'(DONE);
            else               n.en = 1'b1;
        end
        if (d_e && (s0 == IDLE || s0 == PAUSE)) n.up = ~c.up;
        if (s0 == RUN && clr_lvl && !full) n.hold = c.hold + (tk ? 4'd1 : 4'd0);
        else                               n.hold = 4'd0;
        return n;
    endfunction

    always_comb begin
        n_w = step(m_w, 1'b1, se, ce, de, tick, clear_in, count);
        n_s = step(m_s, 1'b0, se, ce, de, tick, clear_in, count);
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_w  <= '{st: 2'd0, en: 1'b0, clr: 1'b0, up: 1'b1, hold: 4'd0};
            m_s  <= '{st: 2'd0, en: 1'b0, clr: 1'b0, up: 1'b1, hold: 4'd0};
            m_sp <= 1'b0;
            m_cp <= 1'b0;
            m_dp <= 1'b0;
        end else begin
            m_w  <= n_w;
            m_s  <= n_s;
            m_sp <= start_in;
            m_cp <= clear_in;
            m_dp <= dir_in;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input mstate_t m, input logic [1:0] st,
                           input logic en, input logic clr, input logic up,
                           input logic rn, input logic dn);
        check({tag, "_state"}, int'(st), int'(m.st));
        check({tag, "_cnt_en"}, int'(en), int'(m.en));
        check({tag, "_cnt_clr"}, int'(clr), int'(m.clr));
        check({tag, "_cnt_up"}, int'(up), int'(m.up));
        check({tag, "_run"}, int'(rn), int'(m.st == 2'(RUN)));
        check({tag, "_done"}, int'(dn), int'(m.st == 2'(DONE)));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if ($time > 2) begin
            cmp_dut("wrap", m_w, st_w, en_w, clr_w, up_w, run_w, done_w);
            cmp_dut("stop", m_s, st_s, en_s, clr_s, up_s, run_s, done_s);
            if (en_w)  en_cnt_w++;
            if (clr_w) clr_cnt_w++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic start_edge();
        start_in = 1'b1;
        nxt();
        start_in = 1'b0;
        nxt();
    endtask

    task automatic dir_edge();
        dir_in = 1'b1;
        nxt();
        dir_in = 1'b0;
        nxt();
    endtask

    task automatic tick_gap(input int gap);
        tick = 1'b1;
        nxt();
        tick = 1'b0;
        repeat (gap) nxt();
    endtask

    initial begin
        int base;
        #2 rst = 1'b0;
        nxt();
        nxt();
        check("reset_state", int'(st_w), 0);
        check("reset_cnt_up", int'(up_w), 1);
        check("reset_cnt_en", int'(en_w), 0);
        check("reset_cnt_clr", int'(clr_w), 0);
        rst = 1'b1;
        nxt();
        nxt();

        // 1: start, five spaced ticks, five single-cycle enables
        start_edge();
        base = en_cnt_w;
        repeat (5) tick_gap(9);
        check("t1_en_pulses", en_cnt_w - base, 5);
        check("t1_state", int'(st_w), RUN);
        check("t1_cnt_up", int'(up_w), 1);

        // 2: pause ignores ticks, direction toggles, resume counts down
        start_edge();
        check("t2_pause_state", int'(st_w), PAUSE);
        base = en_cnt_w;
        repeat (3) tick_gap(4);
        check("t2_pause_no_en", en_cnt_w - base, 0);
        dir_edge();
        check("t2_cnt_up", int'(up_w), 0);
        start_edge();
        check("t2_resume_state", int'(st_w), RUN);
        tick = 1'b1;
        nxt();
        check("t2_en_after_tick", int'(en_w), 1);
        check("t2_en_dir_down", int'(up_w), 0);
        tick = 1'b0;
        nxt();

        // 3: terminal going up: WRAP=0 stops in DONE, WRAP=1 keeps counting
        start_edge();
        dir_edge();
        start_edge();
        count = 14'd9999;
        tick = 1'b1;
        nxt();
        check("t3_stop_no_en", int'(en_s), 0);
        check("t3_stop_state", int'(st_s), DONE);
        check("t3_stop_done", int'(done_s), 1);
        check("t3_wrap_en", int'(en_w), 1);
        check("t3_wrap_state", int'(st_w), RUN);
        tick = 1'b0;
        count = 14'd5;
        start_in = 1'b1;
        nxt();
        check("t3_done_start_clr", int'(clr_s), 1);
        check("t3_done_start_state", int'(st_s), IDLE);
        start_in = 1'b0;
        nxt();
        check("t3_clr_one_cycle", int'(clr_s), 0);

        // 4: terminal going down with wrap
        dir_edge();
        start_edge();
        count = 14'd0;
        tick = 1'b1;
        nxt();
        check("t4_wrap_down_en", int'(en_w), 1);
        check("t4_wrap_down_state", int'(st_w), RUN);
        tick = 1'b0;
        count = 14'd5;
        nxt();

        // 5: interrupted hold does not clear; a full hold does
        base = clr_cnt_w;
        clear_in = 1'b1;
        nxt();
        repeat (2) tick_gap(3);
        clear_in = 1'b0;
        nxt();
        check("t5_short_hold_no_clr", clr_cnt_w - base, 0);
        check("t5_short_hold_state", int'(st_w), RUN);
        clear_in = 1'b1;
        nxt();
        repeat (2) tick_gap(3);
        tick = 1'b1;
        nxt();
        check("t5_hold_clr", int'(clr_w), 1);
        check("t5_hold_no_en", int'(en_w), 0);
        check("t5_hold_state", int'(st_w), IDLE);
        tick = 1'b0;
        clear_in = 1'b0;
        nxt();

        // 6: clear beats start in PAUSE; async reset mid-run
        start_edge();
        start_edge();
        check("t6_pause_state", int'(st_w), PAUSE);
        start_in = 1'b1;
        clear_in = 1'b1;
        nxt();
        check("t6_clear_wins_clr", int'(clr_w), 1);
        check("t6_clear_wins_state", int'(st_w), IDLE);
        start_in = 1'b0;
        clear_in = 1'b0;
        nxt();
        start_edge();
        tick = 1'b1;
        @(posedge clk);
        #2;
        check("t6_pending_en", int'(en_w), 1);
        rst = 1'b0;
        #1;
        check("t6_async_state", int'(st_w), IDLE);
        check("t6_async_cnt_up", int'(up_w), 1);
        check("t6_async_cnt_en", int'(en_w), 0);
        check("t6_async_cnt_clr", int'(clr_w), 0);
        check("t6_async_stop_state", int'(st_s), IDLE);
        tick = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Sequencing controller for the 4-digit counter datapath (clock divider tick -> counter -> BCD/7-segment displays). It consumes debounced push-button levels and the divider tick. It drives the counter's enable, synchronous clear and direction, and exposes run/done status. Operation is a start/pause/resume FSM with terminal-count detection and a hold-to-clear rule while running.

Parameters:
MAX_COUNT, 9999, terminal value in up mode (display limit)
CW, 14, width of count bus (must hold MAX_COUNT)
HOLD_TICKS, 3, consecutive ticks clear_in must stay high to clear while running
WRAP, 1, 1 = counter wraps at terminal and keeps running; 0 = stop in DONE at terminal

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-low reset
start_in  input  1  debounced start/pause button level, synchronous to clk
clear_in  input  1  debounced clear button level
dir_in  input  1  debounced direction button level
tick  input  1  one-cycle count-rate pulse from the clock divider
count  input  CW  current counter value (binary)
cnt_en  output  1  one-cycle increment/decrement strobe to counter
cnt_clr  output  1  one-cycle synchronous clear strobe to counter (counter -> 0)
cnt_up  output  1  direction: 1 = up, 0 = down
run  output  1  high while state == RUN
done  output  1  high while state == DONE
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (rst low, async): state IDLE, cnt_en 0, cnt_clr 0, cnt_up 1, hold counter 0, edge-detect history regs 0. An input already high at reset release therefore registers as a rising edge on the first clock.
- Edge detect: rising edge = input high now, low in previous cycle. All decisions use edges except hold-to-clear, which uses level.
- Terminal condition T: (cnt_up and count == MAX_COUNT) or (!cnt_up and count == 0).
- start edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, DONE->IDLE plus a cnt_clr pulse.
- clear edge in IDLE/PAUSE/DONE: cnt_clr pulse in the following cycle; state -> IDLE.
- clear in RUN:
  - Hold counter increments on each tick while clear_in is high.
  - The hold counter zeroes whenever clear_in is low.
  - On reaching HOLD_TICKS: cnt_clr pulse, state -> IDLE, hold counter -> 0.
  - A tick that completes the hold does not produce cnt_en.
- Counting:
  - Tick in cycle n while in RUN -> cnt_en high in cycle n+1 only.
  - With WRAP=1, cnt_en is issued at T; the counter wraps.
  - With WRAP=0 and T true on the tick, no cnt_en is issued; state -> DONE.
- dir edge toggles cnt_up, accepted only in IDLE or PAUSE; ignored in RUN and DONE.
- Outputs cnt_en, cnt_clr, cnt_up are registered. run, done, state decode directly from the state register.
- Priority within one cycle: clear action > start edge > tick. Simultaneous start and clear edges: clear wins, start is discarded. cnt_clr and cnt_en are never high together.
- Tick in IDLE, PAUSE, or DONE: ignored, no cnt_en.
- Reset asserted mid-operation: immediate return to reset values regardless of state, including any pending strobe.

Test Plan:
1. Release rst with all inputs low; start edge; 5 ticks spaced 10 cycles -> state 01, exactly 5 cnt_en pulses, each exactly 1 cycle after its tick, cnt_up = 1.
2. RUN, start edge -> state 10. 3 ticks -> no cnt_en. dir edge -> cnt_up = 0. Start edge -> state 01. Next tick -> cnt_en with cnt_up = 0.
3. WRAP=0, count = 9999, up, RUN, tick -> no cnt_en, state 11, done = 1. Start edge -> cnt_clr 1 cycle, state 00.
4. WRAP=1, count = 0, down, RUN, tick -> cnt_en asserted, state stays 01.
5. RUN, clear_in held high: after 2 ticks, drop low -> no cnt_clr, hold counter resets. Raise again for 3 ticks -> cnt_clr on the cycle after the 3rd tick, no cnt_en for that tick, state 00.
6. Same-cycle start and clear edges in PAUSE -> cnt_clr, state 00. Assert rst mid-RUN -> state 00, cnt_up 1, strobes 0 asynchronously.
